clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
- Run-time programmable clock-divider controller. Replaces the fixed-ratio divider wherever the divide ratio must change without a reset.
- Accepts a new divide ratio over a valid/ready handshake and applies it only at a period boundary, so no runt pulses appear.
- Sequences start and stop cleanly: O_CLK always finishes its current period and parks low.
- Provides a divided clock O_CLK plus a one-cycle O_TICK enable for logic that stays on I_CLK.

Parameters:
- W, 8, width of the ratio and counter registers.
- DEFAULT_DIV, 20, ratio loaded at reset. Output period = DEFAULT_DIV input cycles.
- MIN_DIV, 2, smallest legal ratio. Must be ≥ 2.

Ports:
- I_CLK, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: run request, level-sensitive.
- cfg_valid, input, 1: new ratio offered.
- cfg_div, input, W: requested ratio N, meaning output period = N I_CLK cycles.
- cfg_ready, output, 1: high when a ratio can be accepted.
- O_CLK, output, 1: divided clock, registered.
- O_TICK, output, 1: one-cycle pulse on the cycle O_CLK rises.
- running, output, 1: high while in RUN or STOPPING.
- cfg_err, output, 1: one-cycle pulse when an illegal ratio is offered.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, cnt=0, div=DEFAULT_DIV, pending cleared.
  - O_CLK=0, O_TICK=0, running=0, cfg_err=0, cfg_ready=0.
  - Deassertion is synchronous to I_CLK. cfg_ready rises 1 cycle after release.
- State IDLE:
  - O_CLK=0, cnt held at 0.
  - On an edge with en=1: go to RUN, cnt←0, O_CLK←1, O_TICK←1. Any pending ratio is applied at this same edge.
  - Latency from en to the first O_CLK high is 1 cycle.
- State RUN:
  - Each edge: cnt←(cnt==div−1) ? 0 : cnt+1.
  - O_CLK←(cnt_next < div/2), using integer floor. Result: high for floor(N/2) cycles, low for N−floor(N/2).
  - O_TICK←(cnt_next==0).
  - Examples: N=2 gives 1,0,1,0. N=20 gives 10 high, 10 low. N=3 gives 1 high, 2 low.
- Period boundary: the edge where cnt==div−1.
  - If pending is valid, div←pending and pending is cleared.
  - cnt_next=0 and O_CLK for the new period are computed with the new div.
- Stopping:
  - In RUN, en=0 sampled on an edge moves to STOPPING. Counting continues unchanged.
  - At the boundary in STOPPING, go to IDLE: cnt←0, O_CLK←0, O_TICK←0. A pending ratio is applied here.
  - en=1 sampled in STOPPING returns to RUN with no gap or phase change.
- Config handshake:
  - Transfer occurs on an edge with cfg_valid && cfg_ready.
  - cfg_ready=!pending_valid. Exception: in IDLE a ratio is written directly to div, so cfg_ready stays 1.
  - Only one pending ratio is held. While it is held, cfg_ready=0 until the boundary that consumes it.
  - Bypass: if a transfer occurs on a boundary edge, or in IDLE, the new value is applied at that same edge and pending is not set.
  - Illegal ratio (cfg_div<MIN_DIV): accepted (handshake completes), discarded, and cfg_err pulses high for exactly 1 cycle. div and pending are unchanged.
- Ratio changes only at boundaries. The in-progress period always completes with the old div, so no O_CLK high or low phase is ever shorter than floor(min(old,new)/2).
- running=1 in RUN and STOPPING, 0 in IDLE.
- Reset mid-period: O_CLK drops to 0 immediately (async) and div returns to DEFAULT_DIV.
- Counter width: cnt is W bits. The maximum ratio is 2^W−1 and it must not overflow (cnt ≤ div−1 always).

Test Plan:
- Reset defaults, en=1 with no config, 100 cycles:
  - First O_CLK high 1 cycle after en.
  - Period 20: 10 high, 10 low.
  - O_TICK pulses every 20 cycles, coincident with the O_CLK rise.
- In IDLE, cfg_div=4 then en=1: O_CLK sequence 1,1,0,0 repeating. cfg_ready stays 1.
- RUN at N=20, offer cfg_div=6 at cnt=5:
  - Accepted, then cfg_ready=0.
  - Current period completes at 20 cycles, then periods of 6 (3 high, 3 low).
  - cfg_ready returns to 1 at the boundary.
- Offer cfg_div=8 exactly on the boundary cycle of N=20 → the next period is 8 cycles immediately, with no pending phase.
- RUN at N=20, drop en at cnt=3:
  - O_CLK completes its low phase, then parks at 0 at the boundary. running falls at the same edge.
  - Separately, drop en at cnt=3 and re-raise it at cnt=12: no gap, period stays 20.
- Illegal ratio and reset:
  - cfg_div=1 and cfg_div=0 → single-cycle cfg_err each, period unchanged.
  - Assert rst_n=0 mid-high-phase → O_CLK=0 without waiting for a clock. After release, the period is back to 20.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run-time programmable clock divider controller
module clk_div_ctrl #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 20,
    parameter int MIN_DIV     = 2
) (
    input  logic         I_CLK,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         O_CLK,
    output logic         O_TICK,
    output logic         running,
    output logic         cfg_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] cnt;
    logic [W-1:0] div;
    logic [W-1:0] pend;
    logic         pend_v;
    logic         init_q;

    logic         wrap;
    logic [W-1:0] cnt_inc;
    logic         xfer;
    logic         legal;
    logic [W-1:0] div_bnd;
    logic [W-1:0] div_eff;

    // A single ratio can be parked; ready stays low until the first edge after reset.
    assign cfg_ready = init_q && !pend_v;

    // Counter step and the ratio that takes effect if this edge is a period boundary.
    always_comb begin
        wrap    = (cnt == div - W'(1));
        cnt_inc = wrap ? '0 : cnt + W'(1);
        xfer    = cfg_valid && cfg_ready;
        legal   = (cfg_div >= W'(MIN_DIV));
        div_bnd = div;
        if (xfer && legal) begin
            div_bnd = cfg_div;
        end else if (pend_v) begin
            div_bnd = pend;
        end
        div_eff = wrap ? div_bnd : div;
    end

    // Run/stop sequencing, ratio handover at boundaries, and registered outputs.
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div     <= W'(DEFAULT_DIV);
            pend    <= '0;
            pend_v  <= 1'b0;
            init_q  <= 1'b0;
            O_CLK   <= 1'b0;
            O_TICK  <= 1'b0;
            running <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            init_q  <= 1'b1;
            cfg_err <= xfer && !legal;
            unique case (state)
                IDLE: begin
                    // No period in flight, so an offered ratio lands immediately.
                    div    <= div_bnd;
                    pend_v <= 1'b0;
                    cnt    <= '0;
                    O_CLK  <= 1'b0;
                    O_TICK <= 1'b0;
                    if (en) begin
                        state   <= RUN;
                        running <= 1'b1;
                        O_CLK   <= 1'b1;
                        O_TICK  <= 1'b1;
                    end
                end
                RUN, STOPPING: begin
                    if (wrap) begin
                        div    <= div_bnd;
                        pend_v <= 1'b0;
                    end else if (xfer && legal) begin
                        pend   <= cfg_div;
                        pend_v <= 1'b1;
                    end
                    if (state == STOPPING && !en && wrap) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        cnt     <= '0;
                        O_CLK   <= 1'b0;
                        O_TICK  <= 1'b0;
                    end else begin
                        state  <= en ? RUN : STOPPING;
                        cnt    <= cnt_inc;
                        O_CLK  <= (cnt_inc < (div_eff >> 1));
                        O_TICK <= wrap;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    cnt     <= '0;
                    O_CLK   <= 1'b0;
                    O_TICK  <= 1'b0;
                end
            endcase
        end
    end

endmodule
